// File: rtl/line_assembler_pkg.sv
// Shared constants for the UART line assembler and its consumers:
// ASCII control codes and the assembler state encoding.
package line_assembler_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

endpackage

// File: rtl/line_assembler.sv
// Collects UART bytes into an edited line (BS/CR handling) and holds the
// completed line, packed MSB-first, until the consumer acknowledges it.
module line_assembler
  import line_assembler_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_vld,
  input  logic [7:0]           rx_data,
  output logic [MAX_LEN*8-1:0] line_data,
  output logic [LEN_W-1:0]     line_len,
  output logic                 line_vld,
  input  logic                 line_ack,
  output logic                 overflow,
  output logic                 dropped
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LAST = LEN_W'(MAX_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       lbuf_q [MAX_LEN];
  logic [7:0]       lbuf_d [MAX_LEN];
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [LEN_W-1:0] cnt_m1;

  assign cnt_m1 = count_q - 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = 1'b0;
    drop_d  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) lbuf_d[i] = lbuf_q[i];

    case (state_q)
      ST_COLLECT: begin
        if (rx_vld) begin
          if (rx_data == ASCII_CR) begin
            state_d = ST_COLLECT;
          end else if (rx_data == ASCII_BS) begin
            if (count_q != '0) begin
              lbuf_d[cnt_m1[IDX_W-1:0]] = 8'h00;
              count_d = cnt_m1;
            end
          end else if (rx_data == ASCII_LF) begin
            if (count_q != '0) begin
              lbuf_d[count_q[IDX_W-1:0]] = ASCII_LF;
              len_d   = count_q + 1'b1;
              state_d = ST_HOLD;
            end
          end else if (count_q == LAST) begin
            // No room left for the terminator: drop the whole line.
            for (int i = 0; i < MAX_LEN; i++) lbuf_d[i] = 8'h00;
            count_d = '0;
            state_d = ST_DISCARD;
          end else begin
            lbuf_d[count_q[IDX_W-1:0]] = rx_data;
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (rx_vld && rx_data == ASCII_LF) begin
          ovf_d   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        drop_d = rx_vld;
        if (line_ack) begin
          for (int i = 0; i < MAX_LEN; i++) lbuf_d[i] = 8'h00;
          count_d = '0;
          len_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) lbuf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      for (int i = 0; i < MAX_LEN; i++) lbuf_q[i] <= lbuf_d[i];
    end
  end

  // First received byte lands in the most significant byte.
  for (genvar k = 0; k < MAX_LEN; k++) begin : g_pack
    assign line_data[(MAX_LEN-1-k)*8 +: 8] = lbuf_q[k];
  end

  assign line_len = len_q;
  assign line_vld = (state_q == ST_HOLD);
  assign overflow = ovf_q;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_line_assembler.sv
// Directed and randomized checks for line_assembler against a queue-based
// model of the line-editing rules.
module tb_line_assembler;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic                 clk, rst, rx_vld, line_ack;
  logic [7:0]           rx_data;
  logic [MAX_LEN*8-1:0] line_data;
  logic [LEN_W-1:0]     line_len;
  logic                 line_vld, overflow, dropped;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit m_hold, m_disc;

  line_assembler #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .line_data(line_data), .line_len(line_len), .line_vld(line_vld),
    .line_ack(line_ack), .overflow(overflow), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit v, input logic [7:0] b, input bit ack);
    @(negedge clk);
    rx_vld = v; rx_data = b; line_ack = ack;
    @(posedge clk);
    #1;
    rx_vld = 1'b0; line_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [MAX_LEN*8-1:0] model_pack();
    logic [MAX_LEN*8-1:0] r = '0;
    for (int k = 0; k < mq.size(); k++) r[(MAX_LEN-1-k)*8 +: 8] = mq[k];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; line_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (line_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", line_vld); end
    total++; if (line_len !== '0) begin bad++; $display("FAIL reset_len got=%0d want=0", line_len); end
    total++; if (line_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", line_data); end
    total++; if (overflow !== 1'b0 || dropped !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", overflow, dropped); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    bit stable = 1'b1;
    send(8'h31); idle(10); send(8'h2B); idle(10); send(8'h32); idle(10);
    total++; if (line_vld !== 1'b0) begin bad++; $display("FAIL basic_pre_vld got=%b want=0", line_vld); end
    send(8'h0A);
    total++; if (line_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%b want=1", line_vld); end
    total++; if (line_len !== 6'd4) begin bad++; $display("FAIL basic_len got=%0d want=4", line_len); end
    total++; if (line_data !== {32'h312B320A, 224'h0}) begin bad++; $display("FAIL basic_data got=%h want=312b320a<<224", line_data); end
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (line_vld !== 1'b1 || line_len !== 6'd4 || line_data !== {32'h312B320A, 224'h0}) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL basic_stable got=%b want=1", stable); end
    drive(1'b0, 8'h00, 1'b1);
    total++; if (line_vld !== 1'b0 || line_len !== '0 || line_data !== '0) begin bad++; $display("FAIL basic_ack got=%b/%0d/%h want=0/0/0", line_vld, line_len, line_data); end
  endtask

  task automatic test_edit();
    send(8'h31); send(8'h32); send(8'h08); send(8'h33); send(8'h0D); send(8'h0A);
    total++; if (line_len !== 6'd3) begin bad++; $display("FAIL edit_len got=%0d want=3", line_len); end
    total++; if (line_data !== {24'h31330A, 232'h0}) begin bad++; $display("FAIL edit_data got=%h want=31330a<<232", line_data); end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_max_len();
    repeat (31) send(8'h39);
    send(8'h0A);
    total++; if (line_vld !== 1'b1 || line_len !== 6'd32) begin bad++; $display("FAIL max_len got=%b/%0d want=1/32", line_vld, line_len); end
    total++; if (line_data[7:0] !== 8'h0A || line_data[255:248] !== 8'h39) begin bad++; $display("FAIL max_data got=%h want=39..390a", line_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_noovf got=%b want=0", overflow); end
    drive(1'b0, 8'h00, 1'b1);
    repeat (32) send(8'h39);
    send(8'h0A);
    total++; if (overflow !== 1'b1 || line_vld !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b/%b want=1/0", overflow, line_vld); end
    idle(1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_width got=%b want=0", overflow); end
    send(8'h35); send(8'h0A);
    total++; if (line_len !== 6'd2 || line_data !== {16'h350A, 240'h0}) begin bad++; $display("FAIL ovf_next got=%0d/%h want=2/350a<<240", line_len, line_data); end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_ack_drop();
    send(8'h39); send(8'h0A);
    drive(1'b1, 8'h37, 1'b1);
    total++; if (dropped !== 1'b1 || line_vld !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b/%b/%b want=1/0/0", dropped, line_vld, overflow); end
    idle(1);
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL drop_width got=%b want=0", dropped); end
    send(8'h38); send(8'h0A);
    total++; if (line_len !== 6'd2 || line_data !== {16'h380A, 240'h0}) begin bad++; $display("FAIL drop_next got=%0d/%h want=2/380a<<240", line_len, line_data); end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_empty();
    send(8'h0A);
    total++; if (line_vld !== 1'b0 || line_len !== '0 || overflow !== 1'b0 || dropped !== 1'b0) begin bad++; $display("FAIL empty_lf got=%b/%0d/%b/%b want=0/0/0/0", line_vld, line_len, overflow, dropped); end
    send(8'h08);
    total++; if (line_vld !== 1'b0 || line_data !== '0 || overflow !== 1'b0 || dropped !== 1'b0) begin bad++; $display("FAIL empty_bs got=%b/%h/%b/%b want=0/0/0/0", line_vld, line_data, overflow, dropped); end
  endtask

  task automatic test_async_reset();
    send(8'h34); send(8'h35);
    total++; if (line_data !== {16'h3435, 240'h0}) begin bad++; $display("FAIL ar_partial got=%h want=3435<<240", line_data); end
    @(posedge clk); #2; rst = 1'b0; #1;
    total++; if (line_data !== '0 || line_vld !== 1'b0 || line_len !== '0) begin bad++; $display("FAIL ar_mid got=%h/%b/%0d want=0/0/0", line_data, line_vld, line_len); end
    @(negedge clk); rst = 1'b1;
    send(8'h36); send(8'h0A);
    total++; if (line_len !== 6'd2 || line_data !== {16'h360A, 240'h0}) begin bad++; $display("FAIL ar_after1 got=%0d/%h want=2/360a<<240", line_len, line_data); end
    @(posedge clk); #3; rst = 1'b0; #1;
    total++; if (line_data !== '0 || line_vld !== 1'b0 || line_len !== '0 || overflow !== 1'b0 || dropped !== 1'b0) begin bad++; $display("FAIL ar_hold got=%h/%b/%0d want=0/0/0", line_data, line_vld, line_len); end
    @(negedge clk); rst = 1'b1;
    send(8'h36); send(8'h0A);
    total++; if (line_len !== 6'd2 || line_data !== {16'h360A, 240'h0}) begin bad++; $display("FAIL ar_after2 got=%0d/%h want=2/360a<<240", line_len, line_data); end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int errs = 0;
    mq.delete(); m_hold = 1'b0; m_disc = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      bit do_ack, do_rx, e_ovf, e_drop, was_hold;
      int r;
      logic [7:0] b;
      do_ack = m_hold && ($urandom_range(0, 1) == 1);
      do_rx  = !do_ack || ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 99);
      if (r < 5)       b = 8'h0A;
      else if (r < 10) b = 8'h08;
      else if (r < 13) b = 8'h0D;
      else             b = 8'($urandom_range(32, 126));
      drive(do_rx, b, do_ack);
      e_ovf = 1'b0; e_drop = 1'b0; was_hold = m_hold;
      if (do_rx) begin
        if (was_hold) e_drop = 1'b1;
        else if (m_disc) begin
          if (b == 8'h0A) begin m_disc = 1'b0; e_ovf = 1'b1; end
        end else if (b == 8'h0D) begin
        end else if (b == 8'h08) begin
          if (mq.size() > 0) void'(mq.pop_back());
        end else if (b == 8'h0A) begin
          if (mq.size() > 0) begin mq.push_back(b); m_hold = 1'b1; end
        end else if (mq.size() < MAX_LEN - 1) mq.push_back(b);
        else begin mq.delete(); m_disc = 1'b1; end
      end
      if (do_ack && was_hold) begin mq.delete(); m_hold = 1'b0; end
      total++;
      if (line_vld !== m_hold || line_len !== LEN_W'(m_hold ? mq.size() : 0) ||
          line_data !== model_pack() || overflow !== e_ovf || dropped !== e_drop) begin
        bad++;
        if (errs < 5) $display("FAIL rand_step%0d got=%b/%0d/%b/%b want=%b/%0d/%b/%b", n,
          line_vld, line_len, overflow, dropped, m_hold, m_hold ? mq.size() : 0, e_ovf, e_drop);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edit();
    test_max_len();
    test_ack_drop();
    test_empty();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_assembler.md
Name: line_assembler

Overview:
- Sits between Reader and Calculator.
- Collects received UART bytes into one line, applies simple line editing (backspace, CR strip), and presents the completed line as a packed word.
- Packing matches what Calculator consumes: first character in the most significant byte, unused bytes zero.
- Replaces the ad-hoc input array and iterator logic in the top-level FSM; completed lines are handed over with a valid/ack handshake.

Parameters:
- MAX_LEN, 32: line capacity in bytes, including the terminating '\n'.
- LEN_W, 6: width of the length output; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- rx_vld  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- line_data  out  MAX_LEN*8  packed line. Byte k (k-th received) sits at bits [(MAX_LEN-1-k)*8 +: 8]; bytes at positions >= line_len are 0.
- line_len  out  LEN_W  number of valid bytes including the '\n'.
- line_vld  out  1  a completed line is held on line_data/line_len.
- line_ack  in  1  consumer accepts the line; sampled only while line_vld=1.
- overflow  out  1  one-cycle pulse: a line exceeded MAX_LEN and was discarded.
- dropped  out  1  one-cycle pulse: a byte arrived while a line was held and was lost.

Behaviour:
- Reset (rst=0, asynchronous): state=COLLECT, buffer all zero, count=0.
  Outputs: line_data=0, line_len=0, line_vld=0, overflow=0, dropped=0.
- Reset mid-line or mid-hold: the partial or held line is lost; no pulses are generated.
- State COLLECT, on rx_vld=1, by byte value:
  - 0x0D (CR): ignored.
  - 0x08 (BS): if count>0, count decrements and that buffer byte is zeroed; if count=0, ignored.
  - 0x0A ('\n'), count=0: empty line, ignored, stay in COLLECT.
  - 0x0A, count>0: the '\n' is stored at position count; line_len=count+1; go to HOLD. line_vld rises on the clock edge that samples the '\n' (1-cycle latency).
  - Any other byte, count<MAX_LEN-1: stored at position count; count increments.
  - Any other byte, count=MAX_LEN-1: no room left for the '\n'; go to DISCARD, clear buffer and count.
- State DISCARD:
  - All bytes ignored except '\n'.
  - On '\n': overflow pulses high for the next cycle; go to COLLECT with an empty buffer; no line is emitted.
- State HOLD:
  - line_vld=1; line_data and line_len are stable.
  - On line_ack=1 at an edge: line_vld falls, buffer/count/line_len are cleared, go to COLLECT.
  - Any rx_vld byte in HOLD, including one in the same cycle as line_ack, is discarded and pulses dropped for one cycle.
- line_data is driven directly from the buffer register, with no combinational path from rx_data.
- overflow and dropped are registered; they never assert in the same cycle as each other in a single event.
- MAX_LEN bytes including the '\n' is legal: 31 characters plus '\n' yields line_len=32.

Decomposition:
- Shared package holds the ASCII constants (ASCII_LF=8'h0A, ASCII_CR=8'h0D, ASCII_BS=8'h08) and the state encoding (COLLECT, DISCARD, HOLD), for reuse by Top and the output formatter.
- Single module, no sub-module. The buffer is a MAX_LEN x 8 register array, flattened into line_data with a generate loop.

Test Plan:
- Send "1+2\n" (0x31,0x2B,0x32,0x0A), spaced 10 cycles apart -> line_vld high 1 cycle after the 0x0A; line_len=4; line_data[255:224]=32'h312B320A, rest 0; hold line_ack=0 for 20 cycles -> outputs stable.
- Send "12",BS,"3\r\n" -> line_len=3; line_data[255:232]=24'h31330A; rest 0.
- Send 31 x 0x39 then '\n' -> line_len=32; line_data[7:0]=8'h0A; no overflow. Then 32 x 0x39 then '\n' -> overflow one-cycle pulse after the '\n'; line_vld stays 0; the next "5\n" yields line_len=2, top bytes 16'h350A.
- In HOLD, send 0x37 in the same cycle as line_ack=1 -> dropped pulse 1 cycle; line_vld falls; the next line "8\n" has line_len=2, top bytes 16'h380A (the 0x37 is absent).
- Send "\n" alone and BS with an empty buffer -> no line_vld, no pulses, line_len stays 0.
- Assert rst=0 asynchronously (mid-clock) after "45" and again during HOLD -> all outputs 0 immediately; after release, "6\n" gives line_len=2, top bytes 16'h360A.
